// File: rtl/calc_cu_chained.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : calc_cu_chained                                            |
// | Description : Calculator control unit and accumulator. Sequences         |
// |               operator/operand entry, runs a WIDTH-bit operation as      |
// |               WIDTH/SLICE carry-chained slice cycles, keeps zero/carry/  |
// |               compare flags, and chains a new operator press into the    |
// |               pending operation.                                         |
// | Options     : CALC_MEM_EN - adds a memory register (opt 6 store,         |
// |               opt 7 recall, edge-detected, IDLE only).                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module calc_cu_chained #(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             workClk,
  input  logic             reset,
  input  logic [2:0]       opt,
  input  logic             optPressed,
  input  logic             numPressed,
  input  logic             submit,
  input  logic [WIDTH-1:0] regValue,
  output logic             erase,
  output logic             showAns,
  output logic [WIDTH-1:0] ans,
  output logic             clcZero,
  output logic             clcCo,
  output logic             cmpSign,
  output logic             busy
);

  localparam int SLICES = (WIDTH / SLICE < 1) ? 1 : WIDTH / SLICE;
  localparam int SIW    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [SIW-1:0]   c_LAST = SIW'(SLICES - 1);
  localparam logic [WIDTH-1:0] c_MASK = WIDTH'({SLICE{1'b1}});

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_OPSEL = 3'd1;
  localparam logic [2:0] c_ENTRY = 3'd2;
  localparam logic [2:0] c_EXEC  = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_AND = 3'd2;
  localparam logic [2:0] c_OP_OR  = 3'd3;
  localparam logic [2:0] c_OP_XOR = 3'd4;
  localparam logic [2:0] c_OP_CMP = 3'd5;

  logic [2:0]       r_state, w_next;
  logic [2:0]       r_opcode, r_pend;
  logic             r_chain;
  logic [SIW-1:0]   r_slice;
  logic             r_carry, r_zero;
  logic [WIDTH-1:0] r_temp, r_ans;
  logic             r_zf, r_co, r_sign, r_erase;

  logic             w_optOk, w_isSub, w_isArith, w_ci, w_co, w_zero;
  logic [31:0]      w_lo;
  logic [WIDTH-1:0] w_shA, w_shB, w_temp;
  logic [SLICE-1:0] w_a, w_b, w_bInv, w_res;
  logic [SLICE:0]   w_sum;

  // Only opcodes 0..5 start or chain an operation; 6 and 7 never do.
  assign w_optOk   = optPressed && (opt <= 3'd5);
  assign w_isSub   = (r_opcode == c_OP_SUB) || (r_opcode == c_OP_CMP);
  assign w_isArith = w_isSub || (r_opcode == c_OP_ADD);

  // One slice of the datapath: select slice k, add/logic, merge into temp.
  always_comb begin
    w_lo   = 32'(r_slice) * 32'(SLICE);
    w_shA  = r_ans >> w_lo;
    w_shB  = regValue >> w_lo;
    w_a    = w_shA[SLICE-1:0];
    w_b    = w_shB[SLICE-1:0];
    w_bInv = w_isSub ? ~w_b : w_b;
    w_ci   = (r_slice == '0) ? w_isSub : r_carry;
    w_sum  = {1'b0, w_a} + {1'b0, w_bInv} + {{SLICE{1'b0}}, w_ci};
    w_res  = w_sum[SLICE-1:0];
    w_co   = w_sum[SLICE];
    case (r_opcode)
      c_OP_AND: begin w_res = w_a & w_b; w_co = 1'b0; end
      c_OP_OR:  begin w_res = w_a | w_b; w_co = 1'b0; end
      c_OP_XOR: begin w_res = w_a ^ w_b; w_co = 1'b0; end
      default:  ;
    endcase
    w_zero = (w_res == '0) && ((r_slice == '0) || r_zero);
    w_temp = (r_temp & ~(c_MASK << w_lo)) | (WIDTH'(w_res) << w_lo);
  end

  // Next-state selection; operator presses win over a simultaneous submit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_optOk) w_next = c_OPSEL; else if (submit) w_next = c_DONE;
      c_OPSEL: if (numPressed) w_next = c_ENTRY;
      c_ENTRY: if (w_optOk || submit) w_next = c_EXEC;
      c_EXEC:  if (r_slice == c_LAST) w_next = c_DONE;
      c_DONE:  if (r_chain) w_next = c_OPSEL; else if (!submit) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

`ifdef CALC_MEM_EN
  logic [WIDTH-1:0] r_mem;
  logic             r_optQ;
  logic             w_memStore, w_memLoad;
  assign w_memStore = (r_state == c_IDLE) && optPressed && !r_optQ && (opt == 3'd6);
  assign w_memLoad  = (r_state == c_IDLE) && optPressed && !r_optQ && (opt == 3'd7);

  // Memory register and operator-key edge detector.
  always_ff @(posedge workClk or negedge reset) begin
    if (!reset) begin
      r_mem  <= '0;
      r_optQ <= 1'b0;
    end else begin
      r_optQ <= optPressed;
      if (w_memStore) r_mem <= r_ans;
    end
  end
`endif

  // Control state, slice sequencing and accumulator/flag writeback.
  always_ff @(posedge workClk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_IDLE;
      r_opcode <= c_OP_ADD;
      r_pend   <= c_OP_ADD;
      r_chain  <= 1'b0;
      r_slice  <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_temp   <= '0;
      r_ans    <= '0;
      r_zf     <= 1'b0;
      r_co     <= 1'b0;
      r_sign   <= 1'b0;
      r_erase  <= 1'b1;
    end else begin
      r_state <= w_next;
      // erase is high for every cycle spent in DONE, including a held submit.
      r_erase <= (w_next == c_DONE);
      if ((w_next != r_state) && ((w_next == c_OPSEL) || (w_next == c_ENTRY))) begin
        r_zf <= 1'b0;
        r_co <= 1'b0;
      end
      case (r_state)
        c_IDLE: begin
          if (w_optOk) r_opcode <= opt;
`ifdef CALC_MEM_EN
          if (w_memLoad) begin
            r_ans  <= r_mem;
            r_zf   <= (r_mem == '0);
            r_co   <= 1'b0;
            r_sign <= 1'b0;
          end
`endif
        end
        c_OPSEL: if (w_optOk) r_opcode <= opt;
        c_ENTRY: begin
          r_slice <= '0;
          if (w_optOk) begin
            r_chain <= 1'b1;
            r_pend  <= opt;
          end else if (submit) begin
            r_chain <= 1'b0;
          end
        end
        c_EXEC: begin
          r_temp  <= w_temp;
          r_carry <= w_co;
          r_zero  <= w_zero;
          // Writeback happens on the last slice edge so ans is already valid in DONE.
          if (r_slice == c_LAST) begin
            r_slice <= '0;
            r_zf    <= w_zero;
            r_co    <= w_isArith ? w_co : 1'b0;
            if (r_opcode == c_OP_CMP) begin
              r_sign <= w_temp[WIDTH-1];
            end else begin
              r_ans  <= w_temp;
              r_sign <= 1'b0;
            end
          end else begin
            r_slice <= r_slice + SIW'(1);
          end
        end
        c_DONE: begin
          if (r_chain) begin
            r_opcode <= r_pend;
            r_chain  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign erase   = r_erase;
  assign busy    = (r_state == c_EXEC);
  assign showAns = !((r_state == c_ENTRY) || (r_state == c_EXEC));
  assign ans     = r_ans;
  assign clcZero = r_zf;
  assign clcCo   = r_co;
  assign cmpSign = r_sign;

endmodule
`default_nettype wire

// File: doc/calc_cu_chained.md
Name: calc_cu_chained

Overview:
- Parametrised calculator control unit and accumulator for the music-calculator datapath.
- Sequences operator and operand entry, then runs a WIDTH-bit operation as a ripple of WIDTH/SLICE carry-chained slice cycles.
- Holds the running answer with zero, carry and compare flags, and drives erase and display-select for the input register and display decoder.
- Adds operator chaining over the two-slice predecessor: a new operator press executes the pending operation and arms the next one.

Parameters:
- WIDTH, 16: accumulator and operand width in bits; must be a multiple of SLICE.
- SLICE, 8: bits processed per EXEC cycle; SLICES = WIDTH/SLICE, minimum 1.

Ports:
- workClk  input  1  work clock from the frequency divider.
- reset  input  1  reset, asynchronous, active-low.
- opt  input  3  operator code.
- optPressed  input  1  operator key level, sampled each workClk.
- numPressed  input  1  digit key level.
- submit  input  1  equals key level.
- regValue  input  WIDTH  operand from the input register.
- erase  output  1  clear request to the input register.
- showAns  output  1  1 = display ans; 0 = display the operand being entered.
- ans  output  WIDTH  accumulator.
- clcZero  output  1  last result was zero.
- clcCo  output  1  carry out of the top slice; for sub, 1 = no borrow.
- cmpSign  output  1  result MSB of the last compare.
- busy  output  1  high during EXEC.

Behaviour:
- Reset: state IDLE, ans=0, all flags 0, busy=0, showAns=1, erase=1, opcode=0, slice index=0. Reset mid-EXEC aborts the operation with no partial writeback.
- Opcodes: 0 add; 1 sub (a+~b, initial ci=1); 2 and; 3 or; 4 xor; 5 cmp (subtract, result discarded); 6 and 7 reserved.
- IDLE:
  - erase drops to 0 on the first clock.
  - optPressed with opt 0..5 latches the opcode and goes to OPSEL; this takes priority over a simultaneous submit.
  - submit alone goes to DONE with ans unchanged.
  - Reserved opcodes: see the optional feature.
- OPSEL:
  - optPressed re-latches the opcode.
  - numPressed goes to ENTRY.
- ENTRY:
  - submit goes to EXEC with chain=0.
  - optPressed goes to EXEC with chain=1 and latches opt as the pending opcode; this takes priority over submit.
- EXEC:
  - One slice per cycle, slice 0 first, for exactly SLICES cycles.
  - Each cycle operates on ans slice k and regValue slice k, using carry-in from slice k-1. Carry is 0 for add and the logic ops, 1 for sub and cmp at slice 0.
  - The result slice goes into a temp register; the zero AND-chain accumulates.
  - The carry out of the last slice goes to co.
- DONE:
  - Entered after the last slice, or directly from IDLE on submit.
  - For ops 0..4: ans <= temp, clcZero and clcCo updated, cmpSign <= 0.
  - For op 5: ans unchanged; clcZero, clcCo and cmpSign (temp MSB) updated.
  - Logic ops force clcCo=0.
  - erase=1 for exactly this one cycle.
  - If chain=1: opcode <= pending opcode, go to OPSEL.
  - Else: go to IDLE once submit is low, otherwise hold in DONE. erase stays high while holding.
- OPSEL and ENTRY clear clcZero and clcCo on entry.
- Latency: submit sampled in ENTRY -> ans valid SLICES+1 workClk edges later.
- busy=1 exactly in EXEC. showAns=0 in ENTRY and EXEC, 1 otherwise.
- regValue must be held stable during EXEC; the input register is erased only in DONE.
- Wrap-around: results are modulo 2^WIDTH; overflow shows only in clcCo.

Optional Feature:
- Macro CALC_MEM_EN.
- Defined:
  - Adds a WIDTH-bit memory register, reset to 0.
  - In IDLE, optPressed with opt=6 stores mem <= ans and stays in IDLE.
  - opt=7 sets ans <= mem, recomputes clcZero, clears clcCo and cmpSign, and stays in IDLE.
  - Each is one action per press: an edge detect on optPressed is required.
- Not defined: opt 6 and 7 are ignored in IDLE and OPSEL. No memory register is built.

Test Plan:
- Reset, then opt=0, num, regValue=0x01FF, submit -> busy for 2 cycles; ans=0x01FF, clcZero=0, clcCo=0; erase pulses in DONE.
- Then opt=0, regValue=0x00FF, submit -> ans=0x02FE, carry propagates slice 0 to slice 1, clcCo=0.
- Then opt=1, regValue=0x02FE, submit -> ans=0x0000, clcZero=1, clcCo=1.
- ans=0x0005, opt=5, regValue=0x0009 -> ans stays 0x0005, cmpSign=1, clcCo=0; with regValue=0x0003 -> cmpSign=0, clcCo=1.
- Chaining: ans=0, opt=0, regValue=0x0010, optPressed with opt=1 in ENTRY -> ans=0x0010, state OPSEL with sub armed; num, regValue=0x0011, submit -> ans=0xFFFF, clcCo=0.
- Reset asserted during the second EXEC cycle -> ans=0, flags 0, IDLE. With CALC_MEM_EN: opt=6 at ans=0x1234, clear via sub, opt=7 -> ans=0x1234.
